// File: rtl/prom_loader.sv
// prom_loader: streams a program image into the 256 x 15-bit program memory.
//
// Accepts instruction words over a valid/ready handshake, writes each accepted
// word one cycle later at sequential addresses starting at BASE_ADDR, keeps a
// running checksum of the loaded words, and holds the CPU in halt from the
// START acceptance through the DONE cycle so fetch never sees a partial image.
//
// Ports:
//   CLK_LD     in   clock, all logic on the rising edge
//   RST_LD     in   synchronous active-high reset, priority over all inputs
//   START      in   one-cycle load request, only honoured in IDLE
//   LEN        in   word count captured at START (0 means 2^AW words)
//   DIN        in   instruction word from the source
//   DIN_VALID  in   DIN holds a word
//   DIN_READY  out  loader accepts a word this cycle (high while in LOAD)
//   WE         out  memory write strobe, one cycle per word
//   W_ADDR     out  memory write address
//   W_DATA     out  memory write data
//   BUSY       out  load in progress
//   HALT_CPU   out  holds PC/fetch while loading, through the DONE cycle
//   DONE       out  one-cycle pulse after the last word is written
//   CHECKSUM   out  sum of loaded words mod 2^DW, held after DONE
module prom_loader #(
  parameter int            AW        = 8,
  parameter int            DW        = 15,
  parameter logic [AW-1:0] BASE_ADDR = 8'h00
) (
  input  logic          CLK_LD,
  input  logic          RST_LD,
  input  logic          START,
  input  logic [AW-1:0] LEN,
  input  logic [DW-1:0] DIN,
  input  logic          DIN_VALID,
  output logic          DIN_READY,
  output logic          WE,
  output logic [AW-1:0] W_ADDR,
  output logic [DW-1:0] W_DATA,
  output logic          BUSY,
  output logic          HALT_CPU,
  output logic          DONE,
  output logic [DW-1:0] CHECKSUM
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Remaining count is one bit wider than the address so LEN==0 can mean 2^AW.
  localparam logic [AW:0] FULL_COUNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE_COUNT  = {{AW{1'b0}}, 1'b1};

  state_t        state_r;
  logic [AW:0]   remaining_r;
  logic [AW-1:0] next_addr_r;
  logic          we_r;
  logic [AW-1:0] w_addr_r;
  logic [DW-1:0] w_data_r;
  logic          busy_r;
  logic          halt_r;
  logic          done_r;
  logic [DW-1:0] checksum_r;
  logic          xfer_s;

  // Checksum accumulation, truncated to the word width.
  function automatic logic [DW-1:0] csum_add(input logic [DW-1:0] acc,
                                             input logic [DW-1:0] word);
    return acc + word;
  endfunction

  assign DIN_READY = (state_r == ST_LOAD);
  assign xfer_s    = DIN_VALID && DIN_READY;

  assign WE       = we_r;
  assign W_ADDR   = w_addr_r;
  assign W_DATA   = w_data_r;
  assign BUSY     = busy_r;
  assign HALT_CPU = halt_r;
  assign DONE     = done_r;
  assign CHECKSUM = checksum_r;

  // Load sequencer: state, counters, checksum and all registered outputs.
  always_ff @(posedge CLK_LD) begin
    if (RST_LD) begin
      state_r     <= ST_IDLE;
      remaining_r <= {(AW+1){1'b0}};
      next_addr_r <= BASE_ADDR;
      we_r        <= 1'b0;
      w_addr_r    <= BASE_ADDR;
      w_data_r    <= {DW{1'b0}};
      busy_r      <= 1'b0;
      halt_r      <= 1'b0;
      done_r      <= 1'b0;
      checksum_r  <= {DW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          we_r   <= 1'b0;
          done_r <= 1'b0;
          if (START) begin
            state_r     <= ST_LOAD;
            remaining_r <= (LEN == {AW{1'b0}}) ? FULL_COUNT : {1'b0, LEN};
            next_addr_r <= BASE_ADDR;
            checksum_r  <= {DW{1'b0}};
            busy_r      <= 1'b1;
            halt_r      <= 1'b1;
          end else begin
            // Halt was kept high through the DONE cycle; release it now.
            busy_r <= 1'b0;
            halt_r <= 1'b0;
          end
        end
        ST_LOAD: begin
          done_r <= 1'b0;
          if (xfer_s) begin
            we_r        <= 1'b1;
            w_addr_r    <= next_addr_r;
            w_data_r    <= DIN;
            next_addr_r <= next_addr_r + {{(AW-1){1'b0}}, 1'b1};
            checksum_r  <= csum_add(checksum_r, DIN);
            remaining_r <= remaining_r - ONE_COUNT;
            if (remaining_r == ONE_COUNT) begin
              state_r <= ST_FINISH;
            end else begin
              state_r <= ST_LOAD;
            end
          end else begin
            we_r <= 1'b0;
          end
        end
        ST_FINISH: begin
          // Last WE is visible during this cycle; DONE follows on the next.
          we_r    <= 1'b0;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          halt_r  <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          we_r    <= 1'b0;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          halt_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prom_loader.sv
// Directed self-checking bench for prom_loader.
module tb_prom_loader;

  logic        CLK_LD = 1'b0;
  logic        RST_LD;
  logic        START;
  logic [7:0]  LEN;
  logic [14:0] DIN;
  logic        DIN_VALID;
  logic        DIN_READY;
  logic        WE;
  logic [7:0]  W_ADDR;
  logic [14:0] W_DATA;
  logic        BUSY;
  logic        HALT_CPU;
  logic        DONE;
  logic [14:0] CHECKSUM;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [7:0]  ea_q[$];
  logic [14:0] ed_q[$];
  logic [7:0]  last_addr = 8'h00;
  logic [14:0] last_data = 15'h0000;
  logic [14:0] dat[256];
  logic [14:0] exp_sum;

  prom_loader dut (
    .CLK_LD(CLK_LD), .RST_LD(RST_LD), .START(START), .LEN(LEN),
    .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY),
    .WE(WE), .W_ADDR(W_ADDR), .W_DATA(W_DATA), .BUSY(BUSY),
    .HALT_CPU(HALT_CPU), .DONE(DONE), .CHECKSUM(CHECKSUM)
  );

  always #5 CLK_LD = ~CLK_LD;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock, then check any write against the expected-write queue.
  task automatic tick();
    logic [7:0]  ea;
    logic [14:0] ed;
    @(posedge CLK_LD);
    #1;
    if (WE) begin
      wr_cnt++;
      if (ea_q.size() == 0) begin
        check_val("we_unexpected", 32'(WE), 32'd0);
      end else begin
        ea = ea_q.pop_front();
        ed = ed_q.pop_front();
        check_val("w_addr", 32'(W_ADDR), 32'(ea));
        check_val("w_data", 32'(W_DATA), 32'(ed));
        last_addr = ea;
        last_data = ed;
      end
    end
    if (DONE) done_cnt++;
  endtask

  task automatic begin_load(input logic [7:0] len);
    START = 1'b1;
    LEN   = len;
    tick();
    START = 1'b0;
    check_val("busy_start", 32'(BUSY), 32'd1);
    check_val("halt_start", 32'(HALT_CPU), 32'd1);
    check_val("ready_start", 32'(DIN_READY), 32'd1);
    exp_sum = 15'h0000;
  endtask

  // Feed nw words from dat[], valid per bit of vpat (1 after bit 31).
  task automatic stream(input int nw, input logic [31:0] vpat, input bit start_mid);
    int idx = 0;
    int k = 0;
    logic v;
    while (idx < nw && k < 1000) begin
      v = (k < 32) ? vpat[k] : 1'b1;
      DIN_VALID = v;
      DIN = dat[idx];
      START = (start_mid && k == 1) ? 1'b1 : 1'b0;
      LEN = 8'd1;
      check_val("ready_load", 32'(DIN_READY), 32'd1);
      if (v) begin
        ea_q.push_back(8'(idx));
        ed_q.push_back(dat[idx]);
        exp_sum = exp_sum + dat[idx];
        idx++;
      end
      tick();
      if (!WE && idx < nw) begin
        check_val("gap_addr_hold", 32'(W_ADDR), 32'(last_addr));
        check_val("gap_data_hold", 32'(W_DATA), 32'(last_data));
      end
      k++;
    end
    DIN_VALID = 1'b0;
    START = 1'b0;
    if (idx < nw) check_val("stream_timeout", 32'(idx), 32'(nw));
  endtask

  // FINISH cycle -> DONE cycle -> optional restart in the DONE cycle.
  task automatic finish_check(input bit restart, input logic [7:0] len2);
    check_val("ready_finish", 32'(DIN_READY), 32'd0);
    check_val("we_finish", 32'(WE), 32'd1);
    tick();
    check_val("done_pulse", 32'(DONE), 32'd1);
    check_val("halt_done", 32'(HALT_CPU), 32'd1);
    check_val("busy_done", 32'(BUSY), 32'd0);
    check_val("we_done", 32'(WE), 32'd0);
    check_val("checksum", 32'(CHECKSUM), 32'(exp_sum));
    check_val("writes_left", 32'(ea_q.size()), 32'd0);
    if (restart) begin
      begin_load(len2);
      check_val("done_drop_r", 32'(DONE), 32'd0);
    end else begin
      tick();
      check_val("done_drop", 32'(DONE), 32'd0);
      check_val("halt_drop", 32'(HALT_CPU), 32'd0);
      check_val("checksum_hold", 32'(CHECKSUM), 32'(exp_sum));
    end
  endtask

  initial begin
    int w0;
    int d0;
    RST_LD = 1'b1; START = 1'b1; DIN_VALID = 1'b1; LEN = 8'd4; DIN = 15'h1234;

    // Reset sanity with START and DIN_VALID held high.
    tick();
    tick();
    check_val("rst_ready", 32'(DIN_READY), 32'd0);
    check_val("rst_we", 32'(WE), 32'd0);
    check_val("rst_busy", 32'(BUSY), 32'd0);
    check_val("rst_halt", 32'(HALT_CPU), 32'd0);
    check_val("rst_done", 32'(DONE), 32'd0);
    check_val("rst_addr", 32'(W_ADDR), 32'h00);
    check_val("rst_data", 32'(W_DATA), 32'h0000);
    check_val("rst_csum", 32'(CHECKSUM), 32'h0000);
    RST_LD = 1'b0; START = 1'b0; DIN_VALID = 1'b0;
    tick();
    check_val("idle_ready", 32'(DIN_READY), 32'd0);

    // Basic load of 4 words; checksum 0x8012 wraps to 0x0012.
    dat[0] = 15'h0001; dat[1] = 15'h0002; dat[2] = 15'h7FFF; dat[3] = 15'h0010;
    w0 = wr_cnt; d0 = done_cnt;
    begin_load(8'd4);
    stream(4, 32'hFFFF_FFFF, 1'b0);
    finish_check(1'b0, 8'd0);
    check_val("basic_csum_const", 32'(CHECKSUM), 32'h0012);
    check_val("basic_writes", 32'(wr_cnt - w0), 32'd4);
    check_val("basic_dones", 32'(done_cnt - d0), 32'd1);

    // Backpressure: valid pattern 1,0,0,1,0,1.
    dat[0] = 15'h0A0A; dat[1] = 15'h0505; dat[2] = 15'h1111;
    w0 = wr_cnt;
    begin_load(8'd3);
    stream(3, 32'h0000_0029, 1'b0);
    finish_check(1'b0, 8'd0);
    check_val("bp_writes", 32'(wr_cnt - w0), 32'd3);

    // Full 256-word load, data = address.
    for (int i = 0; i < 256; i++) dat[i] = 15'(i);
    w0 = wr_cnt;
    begin_load(8'd0);
    stream(256, 32'hFFFF_FFFF, 1'b0);
    check_val("full_last_addr", 32'(W_ADDR), 32'hFF);
    finish_check(1'b0, 8'd0);
    check_val("full_csum_const", 32'(CHECKSUM), 32'h7F80);
    check_val("full_writes", 32'(wr_cnt - w0), 32'd256);
    DIN_VALID = 1'b1;
    tick();
    check_val("extra_ready", 32'(DIN_READY), 32'd0);
    check_val("extra_we", 32'(WE), 32'd0);
    DIN_VALID = 1'b0;

    // Abort after 3 transfers of an 8-word load.
    dat[0] = 15'h0100; dat[1] = 15'h0200; dat[2] = 15'h0300;
    d0 = done_cnt;
    begin_load(8'd8);
    stream(3, 32'hFFFF_FFFF, 1'b0);
    RST_LD = 1'b1; DIN_VALID = 1'b1;
    tick();
    check_val("abort_we", 32'(WE), 32'd0);
    check_val("abort_busy", 32'(BUSY), 32'd0);
    check_val("abort_halt", 32'(HALT_CPU), 32'd0);
    RST_LD = 1'b0; DIN_VALID = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_val("abort_no_done", 32'(done_cnt - d0), 32'd0);
    dat[0] = 15'h0007; dat[1] = 15'h0009;
    begin_load(8'd2);
    stream(2, 32'hFFFF_FFFF, 1'b0);
    finish_check(1'b0, 8'd0);
    check_val("restart_csum_const", 32'(CHECKSUM), 32'h0010);

    // START mid-load ignored; START in the DONE cycle begins a new load.
    dat[0] = 15'h0003; dat[1] = 15'h0004; dat[2] = 15'h0005;
    w0 = wr_cnt;
    begin_load(8'd3);
    stream(3, 32'hFFFF_FFFF, 1'b1);
    finish_check(1'b1, 8'd2);
    check_val("ign_writes", 32'(wr_cnt - w0), 32'd3);
    dat[0] = 15'h0020; dat[1] = 15'h0001;
    stream(2, 32'hFFFF_FFFF, 1'b0);
    finish_check(1'b0, 8'd0);
    check_val("second_csum_const", 32'(CHECKSUM), 32'h0021);
    check_val("second_writes", 32'(wr_cnt - w0), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
